// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and requester indices for the three-way memory port arbiter.
// The index constants also drive the shared-port 3:1 data/address mux.
package mem_port_arbiter_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

    typedef logic [1:0] sel_t;

    localparam sel_t SRC_FETCH = 2'd0;
    localparam sel_t SRC_LSU   = 2'd1;
    localparam sel_t SRC_DMA   = 2'd2;

    localparam int NUM_REQ = 3;

    function automatic logic [NUM_REQ-1:0] src_onehot(input sel_t idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_pick3.sv
// Combinational 3-input priority picker: LSU > fetch > DMA, unless DMA is
// promoted, in which case a pending DMA request beats everything.
module prio_pick3
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_promote,
    output logic [2:0] o_onehot,
    output logic [1:0] o_idx,
    output logic       o_any
);

    sel_t w_idx;

    always_comb begin
        w_idx = SRC_FETCH;
        if (i_promote && i_req[SRC_DMA])
            w_idx = SRC_DMA;
        else if (i_req[SRC_LSU])
            w_idx = SRC_LSU;
        else if (i_req[SRC_FETCH])
            w_idx = SRC_FETCH;
        else if (i_req[SRC_DMA])
            w_idx = SRC_DMA;
    end

    assign o_any    = |i_req;
    assign o_idx    = w_idx;
    assign o_onehot = o_any ? src_onehot(w_idx) : 3'b000;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-state arbiter granting one of fetch / load-store / DMA the shared
// memory port, with DMA starvation promotion and back-to-back handoff.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic       busy
);

    if (DATA_WIDTH < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("mem_port_arbiter: illegal DATA_WIDTH or STARVE_LIMIT");
    end

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t r_state;
    logic [2:0] r_gnt;
    sel_t       r_sel;
    logic       r_mem_valid;
    logic       r_busy;
    logic [7:0] r_starve;

    logic [2:0] w_req_m;
    logic [2:0] w_onehot;
    logic [1:0] w_idx;
    logic       w_any;
    logic       w_promote;
    logic       w_arb;

    // The completing requester is masked so a waiting peer gets the port next.
    assign w_req_m   = (r_state == BUSY) ? (req & ~r_gnt) : req;
    assign w_promote = (r_starve == LIMIT);
    assign w_arb     = (r_state == IDLE) || (r_state == BUSY && mem_ready);

    prio_pick3 u_pick (
        .i_req     (w_req_m),
        .i_promote (w_promote),
        .o_onehot  (w_onehot),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= 3'b000;
            r_sel       <= SRC_FETCH;
            r_mem_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, BUSY: begin
                    if (w_arb) begin
                        if (w_any) begin
                            r_state     <= BUSY;
                            r_gnt       <= w_onehot;
                            r_sel       <= w_idx;
                            r_mem_valid <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_gnt       <= 3'b000;
                            r_mem_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= 3'b000;
                    r_sel       <= SRC_FETCH;
                    r_mem_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve <= 8'd0;
        else if (!req[SRC_DMA] || r_gnt[SRC_DMA])
            r_starve <= 8'd0;
        else if (r_starve != LIMIT)
            r_starve <= r_starve + 8'd1;
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign mem_valid = r_mem_valid;
    assign busy      = r_busy;
    assign done      = r_gnt & {3{mem_ready}};

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the shared memory port; the arbiter passes no data and carries this only so instantiation matches the 3:1 result/address mux.
REQ-002 Parameter STARVE_LIMIT, default 8, number of waiting cycles after which requester 2 is promoted to top priority; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-requester request level: bit0 fetch, bit1 load/store, bit2 debug/DMA.
REQ-006 gnt  output  3  one-hot grant, held for the whole transaction.
REQ-007 done  output  3  one-hot completion pulse, one cycle, for the granted requester.
REQ-008 sel  output  2  select for the shared-port 3:1 mux; encoding 0/1/2 equals requester index.
REQ-009 mem_valid  output  1  transaction active on the shared memory port.
REQ-010 mem_ready  input  1  memory accepts/completes the current transaction this cycle.
REQ-011 busy  output  1  high while state is BUSY.

Function
REQ-012 FSM has exactly two states, IDLE and BUSY; all outputs are registered except done.
REQ-013 IDLE: if req is nonzero, pick a winner, and on the next edge enter BUSY with gnt[winner]=1, sel=winner, mem_valid=1, busy=1.
REQ-014 IDLE with req=0: remain in IDLE, with gnt=0, mem_valid=0, busy=0, and sel holding its last value.
REQ-015 Default priority: load/store (1), then fetch (0), then DMA (2).
REQ-016 When the starvation count equals STARVE_LIMIT, requester 2 wins the next arbitration over all others.
REQ-017 BUSY: hold gnt, sel and mem_valid unchanged until a cycle with mem_ready=1.
REQ-018 done = gnt AND mem_ready, combinational; high in exactly the completion cycle.
REQ-019 On the completion edge, re-arbitrate using the current req with the completing requester's bit masked.
- If another request is pending: enter BUSY with the new winner, no idle bubble.
- Otherwise: enter IDLE.
REQ-020 The masking in REQ-019 applies only on the completion cycle; a requester holding req wins again from IDLE on the following cycle if it still has priority.
REQ-021 A requester deasserting req during BUSY does not abort the transaction: the grant stays until mem_ready, and done still pulses.
REQ-022 sel never takes value 3 and gnt is never multi-hot; any internal illegal state recovers to IDLE on the next edge.
REQ-023 Starvation counter, 8-bit:
- Increments each cycle req[2]=1 and gnt[2]=0.
- Saturates at STARVE_LIMIT.
- Clears to 0 when requester 2 is granted or req[2]=0.
REQ-024 mem_ready while in IDLE is ignored.

Reset
REQ-025 rst_n=0 asynchronously forces IDLE, gnt=0, sel=0, mem_valid=0, busy=0 and starvation count=0; done is then 0 as a consequence.
REQ-026 Reset asserted mid-transaction abandons it with no done pulse; after release, arbitration restarts from IDLE on the first edge.

Structure
REQ-027 A shared package holds the following, and sel is produced from the requester-index constants only:
- arb_state_t enum {IDLE, BUSY}.
- Requester-index constants SRC_FETCH=0, SRC_LSU=1, SRC_DMA=2 (also used by the mux instantiation).
- The 2-bit select typedef.
REQ-028 One sub-module, prio_pick3: a combinational 3-input picker with a promote-DMA input, outputting a one-hot vector plus a 2-bit index.

Verification
REQ-029 Single fetch: req=001, mem_ready high 2 cycles after grant -> gnt=001 and sel=0 for 3 cycles; done=001 on the 3rd; then IDLE.
REQ-030 Contention: req=011 from IDLE -> LSU granted first (sel=1); on its completion, fetch is granted back-to-back (sel=0) with no IDLE cycle.
REQ-031 Starvation, STARVE_LIMIT=8: req=111 held with mem_ready=1 every cycle -> DMA granted (sel=2) no later than the 10th grant; count then reads 0.
REQ-032 Drop request mid-transaction: req=010, deassert 1 cycle after grant, mem_ready 3 cycles later -> gnt stays 010 throughout and done=010 still pulses.
REQ-033 Reset in BUSY: grant DMA, pull rst_n low before mem_ready -> gnt=0, sel=0, mem_valid=0 immediately, no done; req=001 after release -> fetch granted.
REQ-034 Idle noise: req=000 with mem_ready toggling -> gnt, done and mem_valid stay 0, and the state stays IDLE.
